fetch_mem_unit: RTL and testbench
=================================

Name: fetch_mem_unit

Overview:
- Datapath stage directly downstream of the multicycle controller.
- Consumes the controller's PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite and IRWrite strobes.
- Owns the PC, instruction register (IR) and memory data register (MDR), and runs a req/ready handshake to a wait-stated memory.
- Returns `stall`. The controller freezes its state register while `stall` is high.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max BUSY cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pc_write  in  1  unconditional PC update request.
- pc_write_cond  in  1  PC update request, qualified by `zero`.
- zero  in  1  ALU zero flag.
- pc_source  in  2  PC next-value select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold.
- iord  in  1  address select: 0 PC, 1 alu_out.
- mem_read  in  1  data read request; result goes to MDR.
- mem_write  in  1  data write request.
- ir_write  in  1  instruction fetch request; result goes to IR.
- alu_result  in  32  combinational ALU output.
- alu_out  in  32  registered ALU output.
- reg_b  in  32  store data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write qualifier, valid while mem_req=1.
- mem_addr  out  32  latched access address.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete; sampled only in BUSY.
- pc  out  32  program counter.
- instr  out  32  instruction register.
- mdr  out  32  memory data register.
- stall  out  1  controller hold, combinational.
- bus_err  out  1  sticky timeout flag; tied 0 unless FETCH_TIMEOUT_EN is defined.

Behaviour:
- Access request: acc = mem_read | mem_write | ir_write.
- Request priority:
  - mem_write wins: write, no capture.
  - else ir_write: capture to IR.
  - else mem_read: capture to MDR.
- FSM states are IDLE, BUSY and DONE.
  - IDLE, acc=1 → BUSY. Latch mem_addr = iord ? alu_out : pc, mem_we, mem_wdata = reg_b, and the destination. Assert mem_req.
  - IDLE, acc=0 → stay in IDLE.
  - BUSY, mem_ready=1 → DONE. Drop mem_req and mem_we. On a read, capture mem_rdata into IR or MDR at this edge.
  - BUSY, mem_ready=0 → stay in BUSY with mem_req held.
  - DONE → IDLE unconditionally. acc is ignored, because the frozen controller still drives it.
- Stall:
  - stall = (IDLE & acc) | BUSY.
  - stall = 0 in DONE and whenever reset=1.
- Request/complete latency:
  - mem_req rises on the edge after acc is seen.
  - The earliest mem_ready is one cycle later.
  - A zero-wait access holds stall for 2 cycles, then 1 DONE cycle.
- PC update: pc_we = (pc_write | (pc_write_cond & zero)) & ~stall.
  - Non-memory states (branch, jump) update the PC in the same cycle.
  - The fetch state updates the PC in DONE, using the now-valid alu_result.
- PC next value:
  - 00: alu_result.
  - 01: alu_out.
  - 10: {pc[31:26], instr[25:0]}.
  - 11: pc unchanged.
- Arithmetic: all 32-bit, no carry out, wrap silently at 32'hFFFF_FFFF.
- Reset values: pc=RESET_PC; instr=0; mdr=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; bus_err=0; state=IDLE.
- Reset mid-BUSY: abort on that edge. mem_req=0 next cycle. No capture; IR and MDR load reset values.
- mem_ready outside BUSY: ignored.
- mem_rdata: never sampled unless BUSY & mem_ready.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT-1 with no mem_ready: drop mem_req and load 32'h0 into the destination (IR or MDR). IR=0 decodes as NOOP.
  - Set bus_err (sticky until reset) and go to DONE.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins: normal capture, no bus_err.
- Undefined: BUSY waits indefinitely; bus_err tied 0; no counter logic.

Test Plan:
- Reset: assert reset 1 cycle, RESET_PC=32'h100 → pc=32'h100, instr=0, mdr=0, mem_req=0, stall=0.
- Fetch, 0-wait: ir_write=1, pc_write=1, pc_source=00, alu_result=pc+1, mem_ready on first BUSY cycle, mem_rdata=32'h4C00_1234.
  - Expect mem_addr=32'h100, instr=32'h4C00_1234, stall high for 2 cycles.
  - Expect pc=32'h101 after DONE.
- Load with 3 wait states: iord=1, mem_read=1, alu_out=32'h20.
  - Expect mem_req held 4 cycles, mem_addr=32'h20, mdr=mem_rdata, pc unchanged.
- Store plus conflict: mem_write=1 and mem_read=1, reg_b=32'hDEAD_BEEF.
  - Expect mem_we=1, mem_wdata=32'hDEAD_BEEF, mdr unchanged.
- Branch/jump, no memory:
  - pc_write_cond=1, zero=0 → pc holds. Then zero=1, pc_source=01, alu_out=32'h40 → pc=32'h40 same edge, stall=0.
  - pc_source=10, instr[25:0]=26'h3 → pc={pc[31:26],26'h3}.
- Reset mid-BUSY, and timeout (FETCH_TIMEOUT_EN):
  - Reset in BUSY → mem_req=0 next cycle, state IDLE.
  - With the macro, TIMEOUT=16 and no mem_ready → abort after 16 BUSY cycles, instr=0, bus_err=1 until reset.

Source files
------------

// File: rtl/fetch_mem_unit.sv
// PC / IR / MDR datapath stage with a req/ready handshake to a wait-stated memory.
// Define FETCH_TIMEOUT_EN to add a BUSY-state watchdog that aborts the access and sets bus_err.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic [1:0]  pc_source,
    input  logic        iord,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] mdr_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic        dest_ir_reg;
    logic        dest_mdr_reg;

    logic        acc;
    logic        stall_int;
    logic        pc_we;
    logic [31:0] pc_next;

    assign acc       = mem_read | mem_write | ir_write;
    // DONE is deliberately absent: it releases the controller for one cycle.
    assign stall_int = ~reset & (((state_reg == IDLE) & acc) | (state_reg == BUSY));
    assign pc_we     = (pc_write | (pc_write_cond & zero)) & ~stall_int;

    always_comb begin
        pc_next = pc_reg;
        case (pc_source)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc_reg[31:26], instr_reg[25:0]};
            default: pc_next = pc_reg;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       bus_err_reg;

    assign bus_err = bus_err_reg;
`else
    // Without the watchdog the flag can never set.
    assign bus_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            instr_reg     <= '0;
            mdr_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            dest_ir_reg   <= 1'b0;
            dest_mdr_reg  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
            bus_err_reg   <= 1'b0;
`endif
        end else begin
            if (pc_we) begin
                pc_reg <= pc_next;
            end

            case (state_reg)
                IDLE: begin
                    if (acc) begin
                        state_reg     <= BUSY;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= mem_write;
                        mem_addr_reg  <= iord ? alu_out : pc_reg;
                        mem_wdata_reg <= reg_b;
                        // A write suppresses any capture; a fetch outranks a data read.
                        dest_ir_reg   <= ~mem_write & ir_write;
                        dest_mdr_reg  <= ~mem_write & ~ir_write & mem_read;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt_reg   <= '0;
`endif
                    end
                end

                BUSY: begin
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
`endif
                    if (mem_ready) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        if (dest_ir_reg) begin
                            instr_reg <= mem_rdata;
                        end
                        if (dest_mdr_reg) begin
                            mdr_reg <= mem_rdata;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt_reg == 8'(TIMEOUT - 1)) begin
                        // Zeroed IR decodes as NOOP, so the aborted fetch is harmless.
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        bus_err_reg <= 1'b1;
                        if (dest_ir_reg) begin
                            instr_reg <= '0;
                        end
                        if (dest_mdr_reg) begin
                            mdr_reg <= '0;
                        end
                    end
`endif
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pc        = pc_reg;
    assign instr     = instr_reg;
    assign mdr       = mdr_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign stall     = stall_int;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: scoreboarded memory responder, table-driven PC update vectors,
// and hand-written sequences for wait states, reset mid-access and the optional watchdog.
module tb_fetch_mem_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic        zero = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic        iord = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        ir_write = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] reg_b = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        stall;
    logic        bus_err;

    always #5 clk = ~clk;

    fetch_mem_unit #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero),
        .pc_source(pc_source), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .alu_result(alu_result), .alu_out(alu_out), .reg_b(reg_b),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instr(instr), .mdr(mdr), .stall(stall), .bus_err(bus_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard of expected bus transactions, pushed when an access is launched.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        sb_q[$];
    acc_t        sb_e;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic [31:0] rdata_cfg = '0;
    logic        spurious = 1'b0;

    // Memory responder: inserts wait_cfg wait states, then completes and checks the request.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && wait_cnt < wait_cfg) begin
            wait_cnt++;
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (mem_req === 1'b1) begin
            wait_cnt  = 0;
            mem_ready = 1'b1;
            mem_rdata = rdata_cfg;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got request addr %h expected none", mem_addr);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_addr", mem_addr, sb_e.addr);
                check("sb_we", 32'(mem_we), 32'(sb_e.we));
                check("sb_wdata", mem_wdata, sb_e.wdata);
            end
        end else begin
            wait_cnt  = 0;
            mem_ready = spurious;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    task automatic run_access(input logic irw, input logic mrd, input logic mwr, input logic iorda,
                              input logic pcw, input logic [1:0] src,
                              input logic [31:0] a_res, input logic [31:0] a_out, input logic [31:0] rb,
                              input int waits, input logic [31:0] rdata, input logic [31:0] exp_addr,
                              output int stall_cnt, output int req_cnt);
        bit done;
        @(negedge clk);
        wait_cfg  = waits;
        rdata_cfg = rdata;
        sb_q.push_back('{addr: exp_addr, we: mwr, wdata: rb});
        ir_write = irw; mem_read = mrd; mem_write = mwr; iord = iorda;
        pc_write = pcw; pc_write_cond = 1'b0; zero = 1'b0; pc_source = src;
        alu_result = a_res; alu_out = a_out; reg_b = rb;
        #1;
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        req_cnt   = 0;
        done      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1) req_cnt++;
            if (stall !== 1'b1) begin
                done = 1'b1;
                break;
            end
            stall_cnt++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_bound: got stall still high after 100 cycles expected release");
        end
    endtask

    task automatic finish_access();
        @(negedge clk);
        ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; pc_write = 1'b0;
        #1;
    endtask

    typedef struct {
        logic        pcw;
        logic        pcc;
        logic        z;
        logic [1:0]  src;
        logic [31:0] ares;
        logic [31:0] aout;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "simulation hung");
    end

    initial begin
        int sc;
        int rc;

        // Branch / jump vectors, applied once the IR holds 32'h0800_0003 and pc=32'h101.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0,         32'hF000_0040, 32'h0000_0101};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h0,         32'hF000_0040, 32'hF000_0040};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0,         32'h0,         32'hF000_0003};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h7777_7777, 32'h6666_6666, 32'hF000_0003};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h0000_0000};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0200, 32'h0,         32'h0000_0200};

        // Reset, with a fetch strobe present: stall must stay low.
        ir_write = 1'b1;
        @(negedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_pc", pc, RST_PC);
        check("reset_instr", instr, 32'h0);
        check("reset_mdr", mdr, 32'h0);
        check("reset_req", 32'(mem_req), 32'h0);
        check("reset_bus_err", 32'(bus_err), 32'h0);
        reset = 1'b0;
        ir_write = 1'b0;

        // Zero-wait fetch with PC increment in DONE.
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, RST_PC + 32'h1, 32'h0, 32'h0,
                   0, 32'h4C00_1234, 32'h100, sc, rc);
        check("fetch0_stall_cycles", 32'(sc), 32'd2);
        check("fetch0_req_cycles", 32'(rc), 32'd1);
        check("fetch0_instr", instr, 32'h4C00_1234);
        check("fetch0_done_req", 32'(mem_req), 32'h0);
        finish_access();
        check("fetch0_pc", pc, 32'h101);
        check("fetch0_mdr", mdr, 32'h0);

        // Load through alu_out with three wait states.
        run_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h20, 32'h0,
                   3, 32'hCAFE_0001, 32'h20, sc, rc);
        check("load_stall_cycles", 32'(sc), 32'd5);
        check("load_req_cycles", 32'(rc), 32'd4);
        check("load_mdr", mdr, 32'hCAFE_0001);
        check("load_instr", instr, 32'h4C00_1234);
        finish_access();
        check("load_pc", pc, 32'h101);

        // Store with a conflicting read: write wins, MDR untouched.
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h24, 32'hDEAD_BEEF,
                   1, 32'h5555_5555, 32'h24, sc, rc);
        check("store_stall_cycles", 32'(sc), 32'd3);
        check("store_req_cycles", 32'(rc), 32'd2);
        check("store_mdr", mdr, 32'hCAFE_0001);
        check("store_instr", instr, 32'h4C00_1234);
        check("store_done_we", 32'(mem_we), 32'h0);
        finish_access();

        // Fetch the jump instruction (target field 26'h3) with two wait states.
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   2, 32'h0800_0003, 32'h101, sc, rc);
        check("fetch2_stall_cycles", 32'(sc), 32'd4);
        check("fetch2_instr", instr, 32'h0800_0003);
        finish_access();
        check("fetch2_pc", pc, 32'h101);

        // Non-memory PC updates take effect on the same edge with no stall.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pc_write = vecs[i].pcw; pc_write_cond = vecs[i].pcc; zero = vecs[i].z;
            pc_source = vecs[i].src; alu_result = vecs[i].ares; alu_out = vecs[i].aout;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
        end
        @(negedge clk);
        pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;

        // mem_ready while idle must be ignored.
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("spurious_req", 32'(mem_req), 32'h0);
        check("spurious_instr", instr, 32'h0800_0003);
        check("spurious_mdr", mdr, 32'hCAFE_0001);
        spurious = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a stalled access.
        wait_cfg = 255;
        sb_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        ir_write = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midbusy_req", 32'(mem_req), 32'h1);
        check("midbusy_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        check("midbusy_reset_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ir_write = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'h0);
        check("abort_stall", 32'(stall), 32'h0);
        check("abort_instr", instr, 32'h0);
        check("abort_mdr", mdr, 32'h0);
        check("abort_pc", pc, RST_PC);
        check("abort_sb_pending", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        #1;
        check("abort_req_later", 32'(mem_req), 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // mem_ready on the very cycle the watchdog would fire: ready wins.
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   15, 32'h1357_9BDF, 32'h100, sc, rc);
        check("tie_req_cycles", 32'(rc), 32'd16);
        check("tie_instr", instr, 32'h1357_9BDF);
        check("tie_bus_err", 32'(bus_err), 32'h0);
        finish_access();

        // No response at all: abort after 16 BUSY cycles, IR zeroed, sticky bus_err.
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0,
                   255, 32'h0, 32'h100, sc, rc);
        check("tmo_req_cycles", 32'(rc), 32'd16);
        check("tmo_instr", instr, 32'h0);
        check("tmo_bus_err", 32'(bus_err), 32'h1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        finish_access();
        repeat (3) @(negedge clk);
        #1;
        check("tmo_bus_err_sticky", 32'(bus_err), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("tmo_bus_err_cleared", 32'(bus_err), 32'h0);
`else
        check("no_tmo_bus_err", 32'(bus_err), 32'h0);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
